door_lock_ctrl: RTL and testbench

Per-stage door lock controller that sits directly upstream of the door sprite renderer. It collects 4-digit codes from the keyboard decoder and compares each one against the code for the active stage. It drives the registered isLocked flag that the renderer uses to pick the locked or open door sprite. It also raises single-cycle door_pass and fail_req pulses that the top-level game FSM uses to advance to SUCCESSx or FAIL.

---
 rtl/door_lock_ctrl.sv | 167 ++++++++++++++++
 tb/tb_door_lock_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/door_lock_ctrl.sv
// rtl/door_lock_ctrl.sv - per-stage 4-digit door code lock with try counter and entry timeout
// Optional auto-relock in OPEN: define DOOR_LOCK_RELOCK_EN.
module door_lock_ctrl #(
  parameter logic [15:0] CODE_S1     = 16'h1234,
  parameter logic [15:0] CODE_S2     = 16'h5821,
  parameter logic [15:0] CODE_S3     = 16'h9037,
  parameter int          MAX_TRIES   = 3,
  parameter int          TO_W        = 27,
  parameter int          TIMEOUT_CYC = 100_000_000
`ifdef DOOR_LOCK_RELOCK_EN
  , parameter int        RELOCK_CYC  = 200_000_000
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] state,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       at_door,
  output logic       isLocked,
  output logic [2:0] digits_entered,
  output logic [1:0] tries_left,
  output logic       door_pass,
  output logic       fail_req
);

  typedef enum logic [2:0] {IDLE, LOCKED, ENTRY, CHECK, OPEN, PASSED, FAILED} fsm_t;

  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [1:0]      TRIES_MAX = 2'(MAX_TRIES);

  fsm_t            fsm;
  logic [15:0]     code_buf;
  logic [TO_W-1:0] timer;
  logic [3:0]      prev_state;
`ifdef DOOR_LOCK_RELOCK_EN
  logic [31:0]     relock_cnt;
`endif

  logic        is_stage;
  logic        key_num;
  logic        key_clr;
  logic [1:0]  tries_dec;
  logic [15:0] stage_code;

  assign is_stage  = (state == 4'd2) || (state == 4'd4) || (state == 4'd6);
  assign key_num   = key_valid && (key_digit <= 4'd9);
  assign key_clr   = key_valid && (key_digit == 4'hC);
  assign tries_dec = (tries_left == 2'd0) ? 2'd0 : tries_left - 2'd1;

  always_comb begin
    stage_code = CODE_S1;
    case (state)
      4'd4:    stage_code = CODE_S2;
      4'd6:    stage_code = CODE_S3;
      default: stage_code = CODE_S1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm            <= IDLE;
      isLocked       <= 1'b1;
      digits_entered <= 3'd0;
      tries_left     <= TRIES_MAX;
      door_pass      <= 1'b0;
      fail_req       <= 1'b0;
      code_buf       <= 16'h0000;
      timer          <= '0;
      prev_state     <= 4'd0;
`ifdef DOOR_LOCK_RELOCK_EN
      relock_cnt     <= 32'd0;
`endif
    end else begin
      prev_state <= state;
      door_pass  <= 1'b0;
      fail_req   <= 1'b0;
      // Stage changes win over anything the FSM would otherwise do this cycle.
      if (!is_stage) begin
        fsm      <= IDLE;
        isLocked <= 1'b1;
      end else if (state != prev_state) begin
        fsm            <= LOCKED;
        code_buf       <= 16'h0000;
        digits_entered <= 3'd0;
        timer          <= '0;
        tries_left     <= TRIES_MAX;
        isLocked       <= 1'b1;
`ifdef DOOR_LOCK_RELOCK_EN
        relock_cnt     <= 32'd0;
`endif
      end else begin
        case (fsm)
          LOCKED: begin
            if (key_num) begin
              code_buf       <= {code_buf[11:0], key_digit};
              digits_entered <= 3'd1;
              timer          <= '0;
              fsm            <= ENTRY;
            end
          end
          ENTRY: begin
            if (digits_entered == 3'd4) begin
              fsm <= CHECK;
            end else if (key_num) begin
              code_buf       <= {code_buf[11:0], key_digit};
              digits_entered <= digits_entered + 3'd1;
              timer          <= '0;
            end else if (key_clr) begin
              code_buf       <= 16'h0000;
              digits_entered <= 3'd0;
              timer          <= '0;
              fsm            <= LOCKED;
            end else if (!key_valid) begin
              if (timer == TO_LAST) begin
                code_buf       <= 16'h0000;
                digits_entered <= 3'd0;
                timer          <= '0;
                fsm            <= LOCKED;
              end else begin
                timer <= timer + 1'b1;
              end
            end
          end
          CHECK: begin
            if (code_buf == stage_code) begin
              fsm      <= OPEN;
              isLocked <= 1'b0;
`ifdef DOOR_LOCK_RELOCK_EN
              relock_cnt <= 32'd0;
`endif
            end else begin
              tries_left     <= tries_dec;
              code_buf       <= 16'h0000;
              digits_entered <= 3'd0;
              if (tries_dec == 2'd0) begin
                fsm      <= FAILED;
                fail_req <= 1'b1;
              end else begin
                fsm <= LOCKED;
              end
            end
          end
          OPEN: begin
            if (at_door) begin
              door_pass <= 1'b1;
              fsm       <= PASSED;
`ifdef DOOR_LOCK_RELOCK_EN
              relock_cnt <= 32'd0;
            end else if (relock_cnt == 32'(RELOCK_CYC - 1)) begin
              relock_cnt     <= 32'd0;
              code_buf       <= 16'h0000;
              digits_entered <= 3'd0;
              isLocked       <= 1'b1;
              fsm            <= LOCKED;
            end else begin
              relock_cnt <= relock_cnt + 32'd1;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_door_lock_ctrl.sv
// tb/tb_door_lock_ctrl.sv - vector-table bench for door_lock_ctrl
module tb_door_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] state;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       at_door;
  logic       isLocked;
  logic [2:0] digits_entered;
  logic [1:0] tries_left;
  logic       door_pass;
  logic       fail_req;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  door_lock_ctrl #(
    .TIMEOUT_CYC(16)
`ifdef DOOR_LOCK_RELOCK_EN
    , .RELOCK_CYC(32)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .state(state), .key_valid(key_valid),
    .key_digit(key_digit), .at_door(at_door), .isLocked(isLocked),
    .digits_entered(digits_entered), .tries_left(tries_left),
    .door_pass(door_pass), .fail_req(fail_req)
  );

  typedef struct {
    logic [3:0] st;
    logic       kv;
    logic [3:0] kd;
    logic       ad;
    logic       lk;
    logic [2:0] dg;
    logic [1:0] tl;
    logic       dp;
    logic       fr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] st, input logic kv, input logic [3:0] kd, input logic ad,
                     input logic lk, input logic [2:0] dg, input logic [1:0] tl,
                     input logic dp, input logic fr);
    vec_t v;
    v.st = st; v.kv = kv; v.kd = kd; v.ad = ad;
    v.lk = lk; v.dg = dg; v.tl = tl; v.dp = dp; v.fr = fr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic lk, input logic [2:0] dg,
                         input logic [1:0] tl, input logic dp, input logic fr);
    chk({tag, ".isLocked"}, 32'(isLocked), 32'(lk));
    chk({tag, ".digits"}, 32'(digits_entered), 32'(dg));
    chk({tag, ".tries"}, 32'(tries_left), 32'(tl));
    chk({tag, ".door_pass"}, 32'(door_pass), 32'(dp));
    chk({tag, ".fail_req"}, 32'(fail_req), 32'(fr));
  endtask

  task automatic drive(input logic [3:0] st, input logic kv, input logic [3:0] kd, input logic ad);
    @(negedge clk);
    state = st; key_valid = kv; key_digit = kd; at_door = ad;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [3:0] st, input int n);
    for (int i = 0; i < n; i++) drive(st, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic keys(input logic [3:0] st, input logic [15:0] code);
    for (int i = 3; i >= 0; i--) drive(st, 1'b1, code[i*4 +: 4], 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; state = 4'd0; key_valid = 1'b0; key_digit = 4'd0; at_door = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 1'b1, 3'd0, 2'd3, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Stage 1: correct code, unlock two edges after the 4th key, then walk through.
    add(2,0,0,0, 1,0,3,0,0);
    add(2,1,1,0, 1,1,3,0,0);
    add(2,1,2,0, 1,2,3,0,0);
    add(2,1,3,0, 1,3,3,0,0);
    add(2,1,4,0, 1,4,3,0,0);
    add(2,0,0,0, 1,4,3,0,0);
    add(2,0,0,0, 0,4,3,0,0);
    add(2,0,0,1, 0,4,3,1,0);
    add(2,0,0,1, 0,4,3,0,0);
    add(2,0,0,0, 0,4,3,0,0);
    // Stage 2: three wrong codes exhaust the tries.
    add(4,0,0,0, 1,0,3,0,0);
    for (int t = 3; t >= 1; t--) begin
      for (int k = 1; k <= 4; k++) add(4,1,4'(k),0, 1,3'(k),2'(t),0,0);
      add(4,0,0,0, 1,4,2'(t),0,0);
      add(4,0,0,0, 1,0,2'(t-1),0,(t == 1));
    end
    add(4,0,0,0, 1,0,0,0,0);
    add(4,1,5,0, 1,0,0,0,0);
    add(4,1,8,0, 1,0,0,0,0);
    add(4,1,2,0, 1,0,0,0,0);
    add(4,1,1,0, 1,0,0,0,0);
    add(4,0,0,0, 1,0,0,0,0);
    add(4,0,0,0, 1,0,0,0,0);
    // Re-enter stage 2: clear key, ignored key, then correct code.
    add(3,0,0,0, 1,0,0,0,0);
    add(4,0,0,0, 1,0,3,0,0);
    add(4,1,5,0, 1,1,3,0,0);
    add(4,1,8,0, 1,2,3,0,0);
    add(4,1,4'hA,0, 1,2,3,0,0);
    add(4,1,4'hC,0, 1,0,3,0,0);
    add(4,1,4'hC,0, 1,0,3,0,0);
    add(4,1,5,0, 1,1,3,0,0);
    add(4,1,8,0, 1,2,3,0,0);
    add(4,1,2,0, 1,3,3,0,0);
    add(4,1,1,0, 1,4,3,0,0);
    add(4,0,0,0, 1,4,3,0,0);
    add(4,0,0,0, 0,4,3,0,0);
    add(5,0,0,0, 1,4,3,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].st, vecs[i].kv, vecs[i].kd, vecs[i].ad);
      chk_all($sformatf("v%0d", i), vecs[i].lk, vecs[i].dg, vecs[i].tl, vecs[i].dp, vecs[i].fr);
      n_cmp++;
      if (door_pass && fail_req) begin
        n_bad++;
        $display("FAIL v%0d.exclusive: door_pass=%0b fail_req=%0b", i, door_pass, fail_req);
      end
    end

    // Stage 3: entry timeout discards partial buffer.
    drive(6, 1'b0, 4'd0, 1'b0);
    chk_all("to.enter", 1'b1, 3'd0, 2'd3, 1'b0, 1'b0);
    drive(6, 1'b1, 4'd9, 1'b0);
    drive(6, 1'b1, 4'd0, 1'b0);
    chk("to.two", 32'(digits_entered), 32'd2);
    idle(6, 10);
    chk("to.still_two", 32'(digits_entered), 32'd2);
    idle(6, 10);
    chk("to.cleared", 32'(digits_entered), 32'd0);
    keys(6, 16'h9037);
    idle(6, 1);
    chk("to.check_locked", 32'(isLocked), 32'd1);
    idle(6, 1);
    chk_all("to.unlock", 1'b0, 3'd4, 2'd3, 1'b0, 1'b0);

    // Asynchronous reset mid-entry.
    drive(2, 1'b0, 4'd0, 1'b0);
    drive(2, 1'b1, 4'd1, 1'b0);
    drive(2, 1'b1, 4'd2, 1'b0);
    drive(2, 1'b1, 4'd3, 1'b0);
    chk("rst.pre", 32'(digits_entered), 32'd3);
    @(negedge clk);
    key_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all("rst.async", 1'b1, 3'd0, 2'd3, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2, 1'b0, 4'd0, 1'b0);
    chk_all("rst.relocked", 1'b1, 3'd0, 2'd3, 1'b0, 1'b0);

    // OPEN with nobody at the door.
    keys(2, 16'h1234);
    idle(2, 2);
    chk("open.unlock", 32'(isLocked), 32'd0);
`ifdef DOOR_LOCK_RELOCK_EN
    idle(2, 20);
    chk("relock.early", 32'(isLocked), 32'd0);
    idle(2, 12);
    chk("relock.locked", 32'(isLocked), 32'd1);
    chk("relock.tries", 32'(tries_left), 32'd3);
`else
    idle(2, 40);
    chk("open.persist", 32'(isLocked), 32'd0);
    chk("open.no_pass", 32'(door_pass), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
